// File: rtl/relu_maxpool_unit.sv
// relu_maxpool_unit
//
// Post-convolution stage for one horizontal strip. Once the convolution unit
// has filled its strip output memory, this block walks the conv feature map in
// 2x2 / stride-2 windows. It reads the four values of each window, keeps the
// running signed maximum, and writes ReLU(max) into the pooled-strip memory.
//
// Parameters
//   OUT_XSIZE : conv feature-map width
//   OUT_YSIZE : conv feature-map height
//   RD_LAT    : read latency of the strip output memory (1..4 cycles)
//
// Ports
//   clk       : single clock, rising edge
//   reset     : synchronous, active-high
//   start     : level-sensitive request to pool the strip
//   conv_done : convolution unit has finished its strip (sampled in IDLE only)
//   rd_en     : read enable to the strip output memory
//   rd_addr   : conv feature-map read address, row-major
//   rd_data   : conv value, valid RD_LAT cycles after its address
//   wr_en     : write strobe to the pooled memory, one cycle per window
//   wr_addr   : pooled address, row-major
//   wr_data   : ReLU(max of window)
//   done      : strip pooled; held until start drops
module relu_maxpool_unit #(
    parameter int OUT_XSIZE = 222,
    parameter int OUT_YSIZE = 28,
    parameter int RD_LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              conv_done,
    output logic              rd_en,
    output logic [15:0]       rd_addr,
    input  logic signed [8:0] rd_data,
    output logic              wr_en,
    output logic [15:0]       wr_addr,
    output logic signed [8:0] wr_data,
    output logic              done
);

    localparam int POOL_X = OUT_XSIZE / 2;
    localparam int POOL_Y = OUT_YSIZE / 2;

    // Window cycle counter values: RD occupies cycles 0..3, data returns in
    // cycles RD_LAT..RD_LAT+3, and the last return coincides with the last
    // DRAIN cycle.
    localparam logic [3:0]  CAP_FIRST = 4'(RD_LAT);
    localparam logic [3:0]  CAP_LAST  = 4'(RD_LAT + 3);
    localparam logic [15:0] LAST_PCOL = 16'(POOL_X - 1);
    localparam logic [15:0] LAST_PROW = 16'(POOL_Y - 1);
    localparam logic [15:0] XSTEP     = 16'(OUT_XSIZE);
    localparam logic [15:0] ROW_STEP  = 16'(2 * OUT_XSIZE);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        DRAIN,
        WR,
        DONE
    } state_t;

    state_t             r_state;
    logic [3:0]         r_cyc;
    logic [15:0]        r_pcol;
    logic [15:0]        r_prow;
    logic [15:0]        r_rowBase;
    logic [15:0]        r_wrPtr;
    logic signed [8:0]  r_max;
    logic               r_rdEn;
    logic [15:0]        r_rdAddr;
    logic               r_wrEn;
    logic [15:0]        r_wrAddr;
    logic signed [8:0]  r_wrData;
    logic               r_done;

    state_t             w_stateNext;
    logic [3:0]         w_cycNext;
    logic [15:0]        w_pcolNext;
    logic [15:0]        w_prowNext;
    logic [15:0]        w_rowBaseNext;
    logic [15:0]        w_wrPtrNext;
    logic               w_capture;
    logic signed [8:0]  w_maxNext;
    logic [15:0]        w_offset;
    logic               w_rdEnNext;
    logic [15:0]        w_rdAddrNext;
    logic               w_wrEnNext;
    logic [15:0]        w_wrAddrNext;
    logic signed [8:0]  w_wrDataNext;
    logic               w_doneNext;

    // Running maximum. The first returned element of a window overwrites
    // whatever is left from the previous window, so no explicit clear is
    // needed between windows.
    always_comb begin
        w_capture = ((r_state == RD) || (r_state == DRAIN)) &&
                    (r_cyc >= CAP_FIRST) && (r_cyc <= CAP_LAST);
        w_maxNext = r_max;
        if (w_capture && ((r_cyc == CAP_FIRST) || (rd_data > r_max))) begin
            w_maxNext = rd_data;
        end
    end

    // Next-state and window index logic. The row base (2*prow*OUT_XSIZE) and
    // the pooled write pointer are tracked incrementally so no multiplier is
    // needed for either address.
    always_comb begin
        w_stateNext   = r_state;
        w_cycNext     = r_cyc + 4'd1;
        w_pcolNext    = r_pcol;
        w_prowNext    = r_prow;
        w_rowBaseNext = r_rowBase;
        w_wrPtrNext   = r_wrPtr;
        case (r_state)
            IDLE: begin
                w_cycNext     = 4'd0;
                w_pcolNext    = 16'd0;
                w_prowNext    = 16'd0;
                w_rowBaseNext = 16'd0;
                w_wrPtrNext   = 16'd0;
                if (start && conv_done) begin
                    w_stateNext = RD;
                end
            end
            RD: begin
                if (r_cyc == 4'd3) begin
                    w_stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (r_cyc == CAP_LAST) begin
                    w_stateNext = WR;
                end
            end
            WR: begin
                w_cycNext   = 4'd0;
                w_wrPtrNext = r_wrPtr + 16'd1;
                if (r_pcol == LAST_PCOL) begin
                    w_pcolNext    = 16'd0;
                    w_prowNext    = r_prow + 16'd1;
                    w_rowBaseNext = r_rowBase + ROW_STEP;
                end else begin
                    w_pcolNext = r_pcol + 16'd1;
                end
                if ((r_pcol == LAST_PCOL) && (r_prow == LAST_PROW)) begin
                    w_stateNext = DONE;
                end else begin
                    w_stateNext = RD;
                end
            end
            DONE: begin
                w_cycNext = 4'd0;
                if (!start) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so that
    // every output can be registered and still line up with its state.
    always_comb begin
        case (w_cycNext[1:0])
            2'd0:    w_offset = 16'd0;
            2'd1:    w_offset = 16'd1;
            2'd2:    w_offset = XSTEP;
            default: w_offset = XSTEP + 16'd1;
        endcase
        w_rdEnNext   = 1'b0;
        w_rdAddrNext = r_rdAddr;
        w_wrEnNext   = 1'b0;
        w_wrAddrNext = r_wrAddr;
        w_wrDataNext = r_wrData;
        w_doneNext   = 1'b0;
        case (w_stateNext)
            IDLE: begin
                w_rdAddrNext = 16'd0;
                w_wrAddrNext = 16'd0;
                w_wrDataNext = 9'sd0;
            end
            RD: begin
                w_rdEnNext   = 1'b1;
                w_rdAddrNext = w_rowBaseNext + w_pcolNext + w_pcolNext + w_offset;
            end
            WR: begin
                w_wrEnNext   = 1'b1;
                w_wrAddrNext = r_wrPtr;
                w_wrDataNext = w_maxNext[8] ? 9'sd0 : w_maxNext;
            end
            DONE: begin
                w_doneNext = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, indices, running max and registered outputs. Reset drops any
    // window in flight without emitting a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cyc     <= 4'd0;
            r_pcol    <= 16'd0;
            r_prow    <= 16'd0;
            r_rowBase <= 16'd0;
            r_wrPtr   <= 16'd0;
            r_max     <= 9'sd0;
            r_rdEn    <= 1'b0;
            r_rdAddr  <= 16'd0;
            r_wrEn    <= 1'b0;
            r_wrAddr  <= 16'd0;
            r_wrData  <= 9'sd0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_cyc     <= w_cycNext;
            r_pcol    <= w_pcolNext;
            r_prow    <= w_prowNext;
            r_rowBase <= w_rowBaseNext;
            r_wrPtr   <= w_wrPtrNext;
            r_max     <= w_maxNext;
            r_rdEn    <= w_rdEnNext;
            r_rdAddr  <= w_rdAddrNext;
            r_wrEn    <= w_wrEnNext;
            r_wrAddr  <= w_wrAddrNext;
            r_wrData  <= w_wrDataNext;
            r_done    <= w_doneNext;
        end
    end

    assign rd_en   = r_rdEn;
    assign rd_addr = r_rdAddr;
    assign wr_en   = r_wrEn;
    assign wr_addr = r_wrAddr;
    assign wr_data = r_wrData;
    assign done    = r_done;

endmodule
